// File: rtl/i2c_mem_ctrl.sv
// i2c_mem_ctrl: turns the I2C slave byte stream into single-cycle accesses on
// a simple memory bus. It keeps an EEPROM-style auto-incrementing pointer: the
// first byte written after a start loads the pointer, and each later byte is a
// write. Each read request returns the byte at the pointer.
//
// Ports: clk/rst (sync, active-high); start/stop/wr_valid/wr_byte/rd_req come
//   from the byte engine; rd_valid/rd_byte return read data; busy marks an
//   access in flight; err pulses when a request is dropped. addr/cs/we/data
//   form the memory bus, and data is driven only while cs & we.
// Optional: define I2C_MEM_CTRL_WP_EN to add the wp input. With wp high, data
//   writes are suppressed with an err pulse, but the pointer still advances.
module i2c_mem_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_byte,
  input  logic                  rd_req,
`ifdef I2C_MEM_CTRL_WP_EN
  input  logic                  wp,
`endif
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_byte,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  cs,
  output logic                  we,
  inout  wire  [DATA_WIDTH-1:0] data
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WR_ACC, RD_ACC} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic                  do_wr, do_rd, ld_ptr, wp_skip, err_nx;
  logic                  wp_on;

`ifdef I2C_MEM_CTRL_WP_EN
  assign wp_on = wp;
`else
  assign wp_on = 1'b0;
`endif

  // The controller drives the shared bus only during a write access.
  assign data = (cs && we) ? wr_dat : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    ld_ptr   = 1'b0;
    wp_skip  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = ADDR;
        err_nx = wr_valid | rd_req;
      end
      ADDR, DATA: begin
        if (start) begin
          state_nx = ADDR;
          err_nx   = wr_valid | rd_req;
        end else if (stop) begin
          state_nx = IDLE;
          err_nx   = wr_valid | rd_req;
        end else if (wr_valid) begin
          // A write beats a simultaneous read; the read is reported as dropped.
          err_nx = rd_req;
          if (state == ADDR) begin
            ld_ptr   = 1'b1;
            state_nx = DATA;
          end else if (wp_on) begin
            wp_skip = 1'b1;
            err_nx  = 1'b1;
          end else begin
            do_wr    = 1'b1;
            state_nx = WR_ACC;
          end
        end else if (rd_req) begin
          do_rd    = 1'b1;
          state_nx = RD_ACC;
        end
      end
      WR_ACC, RD_ACC: begin
        // Accesses last one cycle. A start/stop seen here is therefore held
        // only until the access ends and takes effect on the following cycle.
        err_nx = wr_valid | rd_req;
        if (start)     state_nx = ADDR;
        else if (stop) state_nx = IDLE;
        else           state_nx = DATA;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      addr     <= '0;
      cs       <= 1'b0;
      we       <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_byte  <= '0;
      wr_dat   <= '0;
    end else begin
      cs       <= do_wr | do_rd;
      we       <= do_wr;
      busy     <= do_wr | do_rd;
      err      <= err_nx;
      rd_valid <= (state == RD_ACC);
      if (do_wr | do_rd) addr   <= ptr;
      if (do_wr)         wr_dat <= wr_byte;
      if (state == RD_ACC) rd_byte <= data;
      if (ld_ptr)
        ptr <= wr_byte[ADDR_WIDTH-1:0];
      else if (wp_skip || state == WR_ACC || state == RD_ACC)
        ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: doc/i2c_mem_ctrl.md
Name: i2c_mem_ctrl

Overview:
Memory-bus initiator for the I2C slave. It converts the byte stream from the I2C byte engine into single-cycle accesses on the simple memory bus (addr/cs/we/shared bidirectional data). It keeps an auto-incrementing address pointer with EEPROM-style semantics: the first written byte after a start sets the pointer, and each later data byte is a write; read requests return the byte at the pointer.

Parameters:
ADDR_WIDTH, 7, memory address width; pointer wraps modulo 2**ADDR_WIDTH
DATA_WIDTH, 8, byte width on both the engine side and the memory side; must be >= ADDR_WIDTH

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse, I2C start or repeated start addressed to this slave
stop  input  1  one-cycle pulse, I2C stop
wr_valid  input  1  one-cycle pulse, wr_byte holds a byte received from the I2C master
wr_byte  input  DATA_WIDTH  received byte
rd_req  input  1  one-cycle pulse, I2C master needs the next read byte
rd_valid  output  1  one-cycle pulse, rd_byte is valid
rd_byte  output  DATA_WIDTH  byte read from memory, held until the next rd_valid
busy  output  1  high while a memory access is in flight
err  output  1  one-cycle pulse when a request is dropped
addr  output  ADDR_WIDTH  memory address, registered
cs  output  1  memory chip select, registered
we  output  1  memory write enable, registered
data  inout  DATA_WIDTH  shared data bus; driven only while cs&we, otherwise 'z

Behaviour:
- Reset (rst=1 at posedge): state IDLE, ptr=0, addr=0, cs=0, we=0, data='z, rd_valid=0, rd_byte=0, busy=0, err=0, internal first-byte flag cleared.
- States:
  - IDLE: no transaction.
  - ADDR: awaiting the address byte.
  - DATA: in a transaction, address byte already received.
  - WR_ACC: one-cycle write access.
  - RD_ACC: one-cycle read access.
- IDLE->ADDR on start. ADDR/DATA->IDLE on stop. start in ADDR or DATA->ADDR (repeated start).
- Address byte (wr_valid in ADDR): ptr <= wr_byte[ADDR_WIDTH-1:0], upper bits ignored, no memory access; next state DATA.
- Write (wr_valid in DATA):
  - Cycle N+1 is WR_ACC: cs=1, we=1, addr=ptr, data=wr_byte registered.
  - ptr increments at the end of N+1.
  - Return to DATA at N+2.
- Read (rd_req in ADDR or DATA):
  - Cycle N+1 is RD_ACC: cs=1, we=0, addr=ptr, data released.
  - At the end of N+1, rd_byte <= data.
  - rd_valid=1 during N+2; ptr increments at the end of N+1.
  - A read in ADDR reads the current pointer; state becomes DATA afterwards.
- busy=1 exactly during WR_ACC and RD_ACC. cs/we are 0 in all other states; addr holds its last value.
- Pointer wraps 2**ADDR_WIDTH-1 -> 0. ptr persists across stop/start and is cleared only by rst.
- wr_valid and rd_req in the same cycle: write wins, rd_req dropped, err=1 next cycle.
- wr_valid/rd_req while in IDLE or during an access state: dropped, err=1 next cycle.
- start/stop during an access state: the access completes unchanged. The event is held pending and applied on the cycle after the access.
- Bus contention is forbidden: the controller never drives data while we=0.
- rst mid-access: cs/we drop at that posedge, no partial write completes afterwards, and any pending start/stop is cleared.

Optional Feature:
- Macro: I2C_MEM_CTRL_WP_EN.
- When defined, adds input port wp (1 bit).
  - Write byte in DATA with wp=1: no memory access (cs stays 0), ptr still increments, err=1 one cycle later.
  - Reads are unaffected.
- When undefined: no wp port, and all writes proceed.

Test Plan:
- rst, start, wr 0x85, wr 0xAA, wr 0xBB, stop -> WR_ACC cycles at addr 0x05 then 0x06 with data 0xAA, 0xBB; ptr=0x07.
- Then start, wr 0x05, rd_req x2 -> rd_valid two cycles after each rd_req with rd_byte 0xAA then 0xBB; data is 'z from the controller in both RD_ACC cycles.
- start, wr 0x7F, wr 0x11, wr 0x22 -> writes land at 0x7F and 0x00 (wrap); ptr=0x01.
- wr_valid and rd_req in the same cycle in DATA -> one write only, err pulse, no rd_valid; rd_req while busy -> err, no access.
- stop asserted during WR_ACC -> the write completes, IDLE the next cycle; rst asserted during RD_ACC -> cs=0 and rd_valid=0 the next cycle, ptr=0.
- With I2C_MEM_CTRL_WP_EN defined, wp=1, start, wr 0x10, wr 0x55 -> cs never asserted, err pulse, ptr=0x11; memory at 0x10 unchanged.
